// File: rtl/ad7928_responder.sv
// Serial-side model of the AD7928 ADC: decodes the 12-bit control word shifted in on DIN
// and returns {0, address, result} from a bank of eight channel values on DOUT.
module ad7928_responder #(
  parameter logic [11:0] CTRL_RESET = 12'h001
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ADC_CS_N,
  input  logic             ADC_SCLK,
  input  logic             ADC_DIN,
  output logic             ADC_DOUT,
  input  logic [7:0][11:0] channel_data,
  output logic [11:0]      ctrl_reg,
  output logic [2:0]       cur_addr,
  output logic             ctrl_valid,
  output logic             frame_done,
  output logic             frame_error
);

  typedef enum logic [1:0] {
    S_WAIT,
    S_IDLE,
    S_FRAME
  } state_t;

  state_t      state, state_nxt;
  logic        cs_q, din_q, sclk_q, sclk_qq;
  logic        armed;
  logic        fall;
  logic [4:0]  fall_cnt, fall_cnt_nxt;
  logic [11:0] in_sh, in_sh_nxt;
  logic [15:0] out_sh, out_sh_nxt;
  logic        dout_nxt;
  logic [11:0] ctrl_nxt;
  logic        valid_nxt, done_nxt, err_nxt;
  logic [11:0] snap;

  // CODING=0 reports two's complement, which for a 12-bit straight-binary value is an MSB flip.
  function automatic logic [11:0] apply_coding(input logic [11:0] v, input logic coding);
    return coding ? v : {~v[11], v[10:0]};
  endfunction

  assign fall     = sclk_qq & ~sclk_q;
  assign cur_addr = ctrl_reg[8:6];
  assign snap     = channel_data[cur_addr];

  // Input conditioning; armed marks that cs_q holds a real sample rather than its reset value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      sclk_qq <= 1'b1;
      din_q   <= 1'b0;
      armed   <= 1'b0;
    end else begin
      cs_q    <= ADC_CS_N;
      sclk_q  <= ADC_SCLK;
      sclk_qq <= sclk_q;
      din_q   <= ADC_DIN;
      armed   <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_WAIT;
      fall_cnt    <= 5'd0;
      in_sh       <= 12'd0;
      out_sh      <= 16'd0;
      ADC_DOUT    <= 1'b0;
      ctrl_reg    <= CTRL_RESET;
      ctrl_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      fall_cnt    <= fall_cnt_nxt;
      in_sh       <= in_sh_nxt;
      out_sh      <= out_sh_nxt;
      ADC_DOUT    <= dout_nxt;
      ctrl_reg    <= ctrl_nxt;
      ctrl_valid  <= valid_nxt;
      frame_done  <= done_nxt;
      frame_error <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fall_cnt_nxt = fall_cnt;
    in_sh_nxt    = in_sh;
    out_sh_nxt   = out_sh;
    dout_nxt     = ADC_DOUT;
    ctrl_nxt     = ctrl_reg;
    valid_nxt    = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      S_WAIT: begin
        if (armed && cs_q) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (!cs_q) begin
          state_nxt    = S_FRAME;
          out_sh_nxt   = {1'b0, cur_addr, apply_coding(snap, ctrl_reg[0])};
          fall_cnt_nxt = 5'd0;
          dout_nxt     = 1'b0;
        end
      end
      S_FRAME: begin
        // CS rise takes priority over a coincident SCLK fall.
        if (cs_q) begin
          state_nxt = S_IDLE;
          dout_nxt  = 1'b0;
          if (fall_cnt == 5'd16) begin
            done_nxt = 1'b1;
            if (in_sh[11]) begin
              ctrl_nxt  = in_sh;
              valid_nxt = 1'b1;
            end
          end else begin
            err_nxt = 1'b1;
          end
        end else if (fall && (fall_cnt < 5'd16)) begin
          dout_nxt     = out_sh[15];
          out_sh_nxt   = {out_sh[14:0], 1'b0};
          fall_cnt_nxt = fall_cnt + 5'd1;
          if (fall_cnt < 5'd12) in_sh_nxt = {in_sh[10:0], din_q};
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_ad7928_responder.sv
// Bench for ad7928_responder: drives SPI frames like the ADC driver and compares the returned
// words, control register and status pulses with a frame-level reference model.
module tb_ad7928_responder;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             ADC_CS_N;
  logic             ADC_SCLK;
  logic             ADC_DIN;
  logic             ADC_DOUT;
  logic [7:0][11:0] channel_data;
  logic [11:0]      ctrl_reg;
  logic [2:0]       cur_addr;
  logic             ctrl_valid;
  logic             frame_done;
  logic             frame_error;

  int          passed = 0;
  int          total  = 0;
  logic [11:0] m_ctrl;
  logic [15:0] got;
  logic [11:0] w;
  int          nf;
  int          r;

  ad7928_responder dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ADC_CS_N     (ADC_CS_N),
    .ADC_SCLK     (ADC_SCLK),
    .ADC_DIN      (ADC_DIN),
    .ADC_DOUT     (ADC_DOUT),
    .channel_data (channel_data),
    .ctrl_reg     (ctrl_reg),
    .cur_addr     (cur_addr),
    .ctrl_valid   (ctrl_valid),
    .frame_done   (frame_done),
    .frame_error  (frame_error)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One driver frame: 3 quiet clocks, then nfalls SCLK periods of 2 low / 2 high clocks.
  // Expected results come from the model state m_ctrl and the channel values at frame start.
  task automatic frame(input string tag, input logic [11:0] word, input int nfalls,
                       input bit simul, input bit mutate, output logic [15:0] res_word);
    logic [2:0]  addr;
    logic [11:0] v;
    logic [11:0] res;
    logic [15:0] expw;
    logic [11:0] exp_ctrl;
    bit          full;
    bit          wr;
    int          nshift;
    addr     = m_ctrl[8:6];
    v        = channel_data[addr];
    res      = m_ctrl[0] ? v : 12'(v + 12'd2048);
    expw     = {1'b0, addr, res};
    full     = (nfalls >= 16);
    wr       = full && word[11];
    exp_ctrl = wr ? word : m_ctrl;
    nshift   = full ? 0 : 16 - nfalls;
    res_word = 16'd0;
    @(posedge clock); #1 ADC_CS_N = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int k = 1; k <= nfalls; k++) begin
      ADC_SCLK = 1'b0;
      ADC_DIN  = (k <= 12) ? word[12-k] : 1'b0;
      repeat (2) @(posedge clock);
      #1;
      if (k <= 16) res_word = {res_word[14:0], ADC_DOUT};
      else check({tag, " overrun_dout"}, 32'(ADC_DOUT), 32'(expw[0]));
      ADC_SCLK = 1'b1;
      if (mutate && k == 1)
        for (int c = 0; c < 8; c++) channel_data[c] = 12'($urandom);
      repeat (2) @(posedge clock);
      #1;
    end
    if (simul) ADC_SCLK = 1'b0;
    ADC_CS_N = 1'b1;
    @(posedge clock); #1;
    check({tag, " pulses_early"}, 32'({frame_done, frame_error, ctrl_valid}), 32'd0);
    @(posedge clock); #1;
    check({tag, " frame_done"}, 32'(frame_done), 32'(full));
    check({tag, " frame_error"}, 32'(frame_error), 32'(!full));
    check({tag, " ctrl_valid"}, 32'(ctrl_valid), 32'(wr));
    check({tag, " ctrl_reg"}, 32'(ctrl_reg), 32'(exp_ctrl));
    check({tag, " dout_end"}, 32'(ADC_DOUT), 32'd0);
    @(posedge clock); #1;
    check({tag, " pulses_late"}, 32'({frame_done, frame_error, ctrl_valid}), 32'd0);
    if (simul) ADC_SCLK = 1'b1;
    check({tag, " word"}, 32'(res_word), 32'(expw >> nshift));
    m_ctrl = exp_ctrl;
    check({tag, " cur_addr"}, 32'(cur_addr), 32'(m_ctrl[8:6]));
  endtask

  initial begin
    reset_n  = 1'b0;
    ADC_CS_N = 1'b1;
    ADC_SCLK = 1'b1;
    ADC_DIN  = 1'b0;
    for (int c = 0; c < 8; c++) channel_data[c] = 12'hFFF;
    m_ctrl = 12'h001;

    // Reset held while the bus toggles
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      ADC_CS_N = i[0];
      ADC_SCLK = i[1];
      ADC_DIN  = i[2];
      check("rst_dout", 32'(ADC_DOUT), 32'd0);
      check("rst_ctrl", 32'(ctrl_reg), 32'h001);
      check("rst_addr", 32'(cur_addr), 32'd0);
      check("rst_pulses", 32'({frame_done, frame_error, ctrl_valid}), 32'd0);
    end

    // Release with CS already low: the in-progress frame must be ignored
    @(posedge clock); #1;
    ADC_CS_N = 1'b0;
    ADC_SCLK = 1'b1;
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 6; k++) begin
      ADC_SCLK = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("noframe_dout", 32'(ADC_DOUT), 32'd0);
      ADC_SCLK = 1'b1;
      repeat (2) @(posedge clock);
      #1;
    end
    ADC_CS_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("noframe_pulses", 32'({frame_done, frame_error, ctrl_valid}), 32'd0);
    end
    check("noframe_ctrl", 32'(ctrl_reg), 32'h001);

    for (int c = 0; c < 8; c++) channel_data[c] = 12'(12'h111 * c + 1);

    // Address pipelining
    frame("pipe_a", 12'h881, 16, 1'b0, 1'b0, got);
    check("pipe_a explicit", 32'(got), 32'h0001);
    frame("pipe_b", 12'h941, 16, 1'b0, 1'b0, got);
    check("pipe_b explicit", 32'(got), 32'h2223);
    frame("pipe_c", 12'h941, 16, 1'b0, 1'b0, got);
    check("pipe_c explicit", 32'(got), 32'h5556);

    // Output coding
    channel_data[3] = 12'h000;
    channel_data[4] = 12'hFFF;
    frame("cod_a", 12'h8C0, 16, 1'b0, 1'b0, got);
    frame("cod_b", 12'h900, 16, 1'b0, 1'b0, got);
    check("cod_b explicit", 32'(got[11:0]), 32'h800);
    frame("cod_c", 12'h901, 16, 1'b0, 1'b0, got);
    check("cod_c explicit", 32'(got[11:0]), 32'h7FF);
    frame("cod_d", 12'h8C1, 16, 1'b0, 1'b0, got);
    check("cod_d explicit", 32'(got[11:0]), 32'hFFF);

    // WRITE=0 leaves the control word alone but still returns data
    frame("nowrite", 12'h7FE, 16, 1'b0, 1'b0, got);
    check("nowrite explicit", 32'(got), 32'h3000);

    // Abort after 9 falls, with the CS rise coinciding with a 10th SCLK fall
    frame("abort", 12'h9C1, 9, 1'b1, 1'b0, got);
    frame("after_abort", 12'h9C1, 16, 1'b0, 1'b0, got);
    check("after_abort explicit", 32'(got), 32'h3000);

    // Falls past 16 are ignored
    frame("overrun", 12'h841, 18, 1'b0, 1'b0, got);
    check("overrun explicit", 32'(got), 32'h7778);

    // Randomized frames, channel data changed mid-frame
    for (int n = 0; n < 40; n++) begin
      w = 12'($urandom);
      if ($urandom_range(0, 3) != 0) w[11] = 1'b1;
      for (int c = 0; c < 8; c++) channel_data[c] = 12'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0)      nf = int'($urandom_range(1, 15));
      else if (r == 1) nf = int'($urandom_range(17, 19));
      else             nf = 16;
      frame($sformatf("rnd%0d", n), w, nf, ($urandom_range(0, 1) == 1), 1'b1, got);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ad7928_responder.md
# ad7928_responder

Synthesizable model of the AD7928 ADC's serial end: an SPI-style responder that sits on the ADC_CS_N/ADC_SCLK/ADC_DIN/ADC_DOUT pins opposite our ADC driver. It decodes the 12-bit control word and returns {leading zero, 3-bit address, 12-bit result} from a bank of eight 12-bit channel values. It is used in simulation benches and on-board loopback builds to exercise the driver and downstream consumers without the physical converter.

## Interface
- CTRL_RESET, 12'h001, control register value after reset (address 0, CODING=1, all other bits 0).
- clock  input  1  system clock, 50 MHz, the same clock as the driver; oversamples SCLK.
- reset_n  input  1  asynchronous, active-low reset.
- ADC_CS_N  input  1  chip select from the driver, active low.
- ADC_SCLK  input  1  serial clock from the driver; idles high.
- ADC_DIN  input  1  control bits from the driver, MSB first.
- ADC_DOUT  output  1  result bits to the driver, MSB first.
- channel_data  input  [7:0][11:0]  analog values to report, in straight binary.
- ctrl_reg  output  12  last accepted control word: [11] WRITE, [10] SEQ, [8:6] ADD, [5:4] PM, [3] SHADOW, [1] RANGE, [0] CODING.
- cur_addr  output  3  channel that the next frame returns (= ctrl_reg[8:6]).
- ctrl_valid  output  1  one-cycle pulse when ctrl_reg is updated.
- frame_done  output  1  one-cycle pulse when a complete frame (≥16 falls) ends.
- frame_error  output  1  one-cycle pulse when CS rises after fewer than 16 falls.

## Operation
- Input conditioning: cs_q, din_q, and sclk_q are registered once; sclk_qq is a second SCLK stage. fall = sclk_qq & ~sclk_q. All registers reset to 1 except din_q, which resets to 0.
- State machine:
  - WAIT (reset state) -> IDLE when cs_q = 1. A frame already in progress at reset release is ignored.
  - IDLE -> FRAME when cs_q = 0. On entry:
    - Snapshot v = channel_data[cur_addr].
    - Load out_sh = {1'b0, cur_addr, v ^ (ctrl_reg[0] ? 12'h000 : 12'h800)}. CODING=0 means two's complement, done by inverting the MSB.
    - Clear fall_cnt; ADC_DOUT = 0.
  - FRAME, on each fall while fall_cnt < 16:
    - ADC_DOUT <= out_sh[15]; out_sh <= out_sh << 1; fall_cnt++. Fall k therefore presents word bit 16-k.
    - If fall_cnt < 12 before the increment, in_sh <= {in_sh[10:0], din_q}.
  - FRAME, falls beyond 16: ignored. ADC_DOUT holds its last bit and fall_cnt saturates at 16.
  - FRAME -> IDLE when cs_q = 1:
    - fall_cnt = 16: pulse frame_done. If in_sh[11] = 1 (WRITE), also ctrl_reg <= in_sh and pulse ctrl_valid.
    - fall_cnt < 16: pulse frame_error; ctrl_reg is unchanged.
    - In both cases ADC_DOUT <= 0.
- Address pipelining: a frame returns the channel selected by the previously accepted control word, not by the word it carries.
- SEQ, SHADOW, PM, and RANGE are stored and reported only; they do not change behaviour.
- Simultaneous CS rise and SCLK fall in the same cycle: the CS rise wins and the fall is ignored.
- channel_data changes mid-frame do not affect the frame in progress.
- Reset values: ADC_DOUT 0, ctrl_reg CTRL_RESET, cur_addr 3'd0, ctrl_valid/frame_done/frame_error 0, fall_cnt 0, in_sh 0, out_sh 0, state WAIT.

## Timing
- ADC_SCLK low after edge e: fall is detected in the cycle after e+1, and ADC_DOUT is updated at edge e+2. This is valid before the driver samples at e+3 (its fixed 2-low/2-high SCLK pattern).
- DIN is sampled from din_q at the fall cycle, i.e. the value present on ADC_DIN at edge e+1.
- CS rise seen raw after edge e: ctrl_reg, ctrl_valid, frame_done, and frame_error update at edge e+2. Pulses are exactly one clock wide.
- Input requirements: each SCLK phase lasts at least 2 clocks; CS stays high at least 2 clocks between frames.
- The driver's 3-cycle quiet period and 64-cycle frame meet these requirements.

## Test plan
- Reset: hold reset_n low while toggling CS/SCLK -> ADC_DOUT=0, ctrl_reg=12'h001, cur_addr=0, no pulses. Release with CS low -> no frame starts until CS has been seen high.
- Loopback with the driver (CODING=1, RANGE=0), channel_data[k]=12'h111*k+1 -> after 3 full address sweeps, the driver's data[k] equals channel_data[k] for all k = 0..7.
- Pipelining: with cur_addr=2, send a frame with ADD=5 -> the captured word is {0,3'd2,ch2}; the next frame returns {0,3'd5,ch5}; ctrl_valid pulses once per frame.
- Coding: accept a control word with CODING=0, then read a channel holding 12'h000 and one holding 12'hFFF -> results 12'h800 and 12'h7FF; restoring CODING=1 returns raw values.
- WRITE=0 frame -> frame_done pulses, ctrl_reg/cur_addr unchanged, ctrl_valid stays 0, data still returned.
- Abort: raise CS after 9 falls -> frame_error pulses for 1 cycle, ctrl_reg unchanged, ADC_DOUT=0. The following full frame decodes normally.
